// File: rtl/session_pkg.sv
// rtl/session_pkg.sv - shared state, LCD and LED codes for the session controller
package session_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOGIN   = 3'd1,
    LOCKOUT = 3'd2,
    MENU    = 3'd3,
    RUN     = 3'd4
  } state_t;

  localparam logic [3:0] LCD_WELCOME = 4'd0;
  localparam logic [3:0] LCD_LOGIN   = 4'd1;
  localparam logic [3:0] LCD_INVALID = 4'd2;
  localparam logic [3:0] LCD_MENU    = 4'd3;
  localparam logic [3:0] LCD_RUNNING = 4'd4;
  localparam logic [3:0] LCD_LOGOUT  = 4'd5;
  localparam logic [3:0] LCD_LOCKED  = 4'd6;
  localparam logic [3:0] LCD_TIMEOUT = 4'd7;

  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_RED   = 2'd1;
  localparam logic [1:0] LED_GREEN = 2'd2;
  localparam logic [1:0] LED_AMBER = 2'd3;

  // A single application still needs a one-bit cursor port.
  function automatic int cursor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - registered rising-edge detector, one event cycle per 0->1 transition
module button_edge #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= '0;
      rise <= '0;
    end else begin
      prev <= raw;
      rise <= raw & ~prev;
    end
  end

endmodule

// File: rtl/session_controller.sv
// rtl/session_controller.sv - welcome/login/menu/run sequencer; SESSION_TIMEOUT_EN adds a menu inactivity timeout
module session_controller
  import session_pkg::*;
#(
  parameter int NUM_APPS     = 2,
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_CYCLES  = 1000,
  parameter int IDLE_TIMEOUT = 5000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2:0]                        buttons,
  input  logic                              access_ok,
  input  logic                              access_fail,
  input  logic [NUM_APPS-1:0]               app_done,
  output logic [cursor_w(NUM_APPS)-1:0]     app_cursor,
  output logic [NUM_APPS-1:0]               app_run,
  output logic                              access_en,
  output logic                              access_clear,
  output logic [3:0]                        lcd_msg,
  output logic [1:0]                        led_state,
  output logic                              locked
);

  localparam int CW = cursor_w(NUM_APPS);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  logic [2:0] evt;
  logic       b0, b1, b2;

  button_edge #(.WIDTH(3)) u_btn (
    .clk  (clk),
    .rst  (rst),
    .raw  (buttons),
    .rise (evt)
  );

  assign b0 = evt[0];
  assign b1 = evt[1];
  assign b2 = evt[2];

  state_t              state, state_n;
  logic [CW-1:0]       cursor_n;
  logic [NUM_APPS-1:0] run_n;
  logic                en_n, clr_n, locked_n;
  logic [3:0]          lcd_n;
  logic [1:0]          led_n;
  logic [3:0]          fail_cnt, fail_n, fail_inc;
  logic [TW-1:0]       lock_tmr, lock_n;
`ifdef SESSION_TIMEOUT_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0]       idle_cnt, idle_n;
`endif

  assign fail_inc = (fail_cnt >= 4'(MAX_FAILS)) ? fail_cnt : fail_cnt + 4'd1;

  always_comb begin
    state_n  = state;
    cursor_n = app_cursor;
    run_n    = app_run;
    lcd_n    = lcd_msg;
    led_n    = led_state;
    clr_n    = 1'b0;
    fail_n   = fail_cnt;
    lock_n   = (lock_tmr != '0) ? lock_tmr - TW'(1) : '0;
`ifdef SESSION_TIMEOUT_EN
    idle_n   = '0;
`endif
    case (state)
      IDLE: begin
        if (b0) begin
          state_n = LOGIN;
          lcd_n   = LCD_LOGIN;
          led_n   = LED_RED;
        end
      end
      LOGIN: begin
        if (b0) begin
          state_n = IDLE;
          clr_n   = 1'b1;
          lcd_n   = LCD_WELCOME;
          led_n   = LED_OFF;
        end else if (access_fail) begin
          fail_n = fail_inc;
          lcd_n  = LCD_INVALID;
          if (fail_inc >= 4'(MAX_FAILS)) begin
            state_n = LOCKOUT;
            clr_n   = 1'b1;
            lock_n  = TW'(LOCK_CYCLES - 1);
            lcd_n   = LCD_LOCKED;
          end
        end else if (access_ok) begin
          state_n = MENU;
          fail_n  = '0;
          lcd_n   = LCD_MENU;
          led_n   = LED_GREEN;
        end
      end
      LOCKOUT: begin
        // Timer was loaded with LOCK_CYCLES-1, so exit lands exactly LOCK_CYCLES cycles after entry.
        if (lock_tmr == '0) begin
          state_n = IDLE;
          fail_n  = '0;
          lcd_n   = LCD_WELCOME;
          led_n   = LED_OFF;
        end
      end
      MENU: begin
`ifdef SESSION_TIMEOUT_EN
        idle_n = idle_cnt + IW'(1);
`endif
        if (b0) begin
          state_n = IDLE;
          clr_n   = 1'b1;
          lcd_n   = LCD_LOGOUT;
          led_n   = LED_OFF;
        end else if (b2) begin
          state_n = RUN;
          run_n   = NUM_APPS'(1) << app_cursor;
          lcd_n   = LCD_RUNNING;
          led_n   = LED_AMBER;
        end else if (b1) begin
          cursor_n = (app_cursor == CW'(NUM_APPS - 1)) ? '0 : app_cursor + CW'(1);
`ifdef SESSION_TIMEOUT_EN
          idle_n   = '0;
        end else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
          state_n = IDLE;
          clr_n   = 1'b1;
          lcd_n   = LCD_TIMEOUT;
          led_n   = LED_OFF;
`endif
        end
      end
      RUN: begin
        if (b0) begin
          state_n = IDLE;
          run_n   = '0;
          clr_n   = 1'b1;
          lcd_n   = LCD_LOGOUT;
          led_n   = LED_OFF;
        end else if (app_done[app_cursor]) begin
          state_n = MENU;
          run_n   = '0;
          lcd_n   = LCD_MENU;
          led_n   = LED_GREEN;
        end
      end
      default: begin
        state_n = IDLE;
        run_n   = '0;
        lcd_n   = LCD_WELCOME;
        led_n   = LED_OFF;
      end
    endcase
    en_n     = (state_n == LOGIN);
    locked_n = (state_n == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      app_cursor   <= '0;
      app_run      <= '0;
      access_en    <= 1'b0;
      access_clear <= 1'b0;
      lcd_msg      <= LCD_WELCOME;
      led_state    <= LED_OFF;
      locked       <= 1'b0;
      fail_cnt     <= '0;
      lock_tmr     <= '0;
`ifdef SESSION_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      state        <= state_n;
      app_cursor   <= cursor_n;
      app_run      <= run_n;
      access_en    <= en_n;
      access_clear <= clr_n;
      lcd_msg      <= lcd_n;
      led_state    <= led_n;
      locked       <= locked_n;
      fail_cnt     <= fail_n;
      lock_tmr     <= lock_n;
`ifdef SESSION_TIMEOUT_EN
      idle_cnt     <= idle_n;
`endif
    end
  end

endmodule
